// File: rtl/regfile_rdport_arbiter_if.sv
// Register-file read-port bus: requester side, mux side and tagged read return.
// master = decode/debug logic plus the 32:1 mux; slave = the arbiter.
interface regfile_rdport_arbiter_if #(
   parameter int NREQ = 3,
   parameter int DW   = 32,
   parameter int AW   = 5
);
   logic [NREQ-1:0]    Req;
   logic [NREQ*AW-1:0] Addr;
   logic               Stall;
   logic [NREQ-1:0]    Gnt;
   logic [AW-1:0]      Sel;
   logic [DW-1:0]      MuxDout;
   logic [DW-1:0]      RdData;
   logic               RdValid;
   logic [1:0]         RdId;

   modport slave (
      input  Req, Addr, Stall, MuxDout,
      output Gnt, Sel, RdData, RdValid, RdId
   );

   modport master (
      output Req, Addr, Stall, MuxDout,
      input  Gnt, Sel, RdData, RdValid, RdId
   );
endinterface

// File: rtl/regfile_rdport_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NREQ requesters.
// S0: combinational grant; S1: registered mux select; S2: captured data tagged
// with the owning requester. Stall freezes every register.
module regfile_rdport_arbiter #(
   parameter int NREQ    = 3,
   parameter int DW      = 32,
   parameter int AW      = 5,
   parameter bit ZERO_R0 = 1'b1
) (
   input  logic                   Clk,
   input  logic                   Rst,
   regfile_rdport_arbiter_if.slave bus
);
   // Requester ids travel on a 2-bit RdId, so NREQ is capped at 4.
   localparam int IW = 2;

   logic [AW-1:0]     addr_a [NREQ];
   logic [2*NREQ-1:0] req2;
   logic [NREQ-1:0]   req_rot;
   logic [NREQ-1:0]   gnt;
   logic              gnt_any;
   logic [IW-1:0]     gnt_idx;
   int                slot;

   logic [AW-1:0] sel_q,      sel_d;
   logic          v1_q,       v1_d;
   logic [IW-1:0] id1_q,      id1_d;
   logic [IW-1:0] ptr_q,      ptr_d;
   logic [DW-1:0] rd_data_q,  rd_data_d;
   logic          rd_valid_q, rd_valid_d;
   logic [IW-1:0] rd_id_q,    rd_id_d;

   for (genvar g = 0; g < NREQ; g++) begin : g_addr
      assign addr_a[g] = bus.Addr[g*AW +: AW];
   end

   // Round-robin pick: rotate Req so the pointer lands on bit 0, take the
   // first set bit, then map the offset back to a requester index mod NREQ.
   always_comb begin
      req2    = {bus.Req, bus.Req};
      req_rot = req2[ptr_q +: NREQ];
      gnt_any = 1'b0;
      gnt_idx = '0;
      slot    = 0;
      gnt     = '0;
      if (!Rst && !bus.Stall) begin
         for (int j = 0; j < NREQ; j++) begin
            if (!gnt_any && req_rot[j]) begin
               gnt_any = 1'b1;
               slot    = int'(ptr_q) + j;
               if (slot >= NREQ) slot = slot - NREQ;
               gnt_idx = IW'(slot);
            end
         end
      end
      if (gnt_any) gnt[gnt_idx] = 1'b1;
   end

   // Next state for S1 (select/id/valid/pointer) and S2 (data capture).
   // Sel only moves on a grant so the mux select never toggles needlessly.
   always_comb begin
      sel_d      = sel_q;
      v1_d       = v1_q;
      id1_d      = id1_q;
      ptr_d      = ptr_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_valid_q;
      rd_id_d    = rd_id_q;
      if (!bus.Stall) begin
         if (gnt_any) begin
            sel_d = addr_a[gnt_idx];
            id1_d = gnt_idx;
            v1_d  = 1'b1;
            ptr_d = (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + IW'(1);
         end else begin
            v1_d = 1'b0;
         end
         rd_valid_d = v1_q;
         rd_id_d    = id1_q;
         if (v1_q) begin
            rd_data_d = (ZERO_R0 && sel_q == '0) ? '0 : bus.MuxDout;
         end
      end
   end

   // Pipeline registers; async reset discards any read in flight.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         sel_q      <= '0;
         v1_q       <= 1'b0;
         id1_q      <= '0;
         ptr_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_id_q    <= '0;
      end else begin
         sel_q      <= sel_d;
         v1_q       <= v1_d;
         id1_q      <= id1_d;
         ptr_q      <= ptr_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         rd_id_q    <= rd_id_d;
      end
   end

   assign bus.Gnt     = gnt;
   assign bus.Sel     = sel_q;
   assign bus.RdData  = rd_data_q;
   assign bus.RdValid = rd_valid_q;
   assign bus.RdId    = rd_id_q;
endmodule

// File: tb/tb_regfile_rdport_arbiter.sv
// Bench for regfile_rdport_arbiter: directed vector table, async-reset sequence,
// then randomized traffic against a queue-based reference model.
// Two DUTs share the same inputs: one with ZERO_R0=1, one with ZERO_R0=0.
module tb_regfile_rdport_arbiter;
   logic Clk;
   logic Rst;
   int   errors = 0;
   int   checks = 0;

   regfile_rdport_arbiter_if #(.NREQ(3), .DW(32), .AW(5)) if0 ();
   regfile_rdport_arbiter_if #(.NREQ(3), .DW(32), .AW(5)) if1 ();

   regfile_rdport_arbiter #(.NREQ(3), .DW(32), .AW(5), .ZERO_R0(1'b1)) dut (
      .Clk(Clk), .Rst(Rst), .bus(if0.slave));
   regfile_rdport_arbiter #(.NREQ(3), .DW(32), .AW(5), .ZERO_R0(1'b0)) dut_nz (
      .Clk(Clk), .Rst(Rst), .bus(if1.slave));

   // Register-file mux model: r0 reads all-ones so the zero rule is visible.
   function automatic logic [31:0] mux_f(logic [4:0] r);
      return (r == 5'd0) ? 32'hFFFF_FFFF : {16'hDEAD, 11'd0, r};
   endfunction

   assign if0.MuxDout = mux_f(if0.Sel);
   assign if1.MuxDout = mux_f(if1.Sel);
   assign if1.Req     = if0.Req;
   assign if1.Addr    = if0.Addr;
   assign if1.Stall   = if0.Stall;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rst;
      logic [2:0]  req;
      logic [4:0]  a0, a1, a2;
      logic        stall;
      logic [2:0]  gnt;
      logic [4:0]  sel;
      logic        vld;
      logic [1:0]  id;
      logic [31:0] dat;
      logic [31:0] dat_nz;
   } vec_t;

   typedef struct {
      int         id;
      logic [4:0] addr;
      int         rem;
   } rd_t;

   vec_t tbl [20];

   initial begin
      rd_t        pend [$];
      rd_t        it;
      int         mptr, eg, prev_g;
      logic [4:0] m_sel;
      logic       m_vld;
      int         m_id;
      logic [31:0] m_dat, m_dat_nz;
      logic       cur_req [3];
      logic [4:0] cur_addr [3];
      logic [2:0] rq;
      logic [2:0] exp_g;

      // rst, req, a0, a1, a2, stall | gnt, sel, vld, id, dat, dat_nz
      tbl[0]  = '{1'b1, 3'b111, 5'd10, 5'd11, 5'd12, 1'b0, 3'b000, 5'd0,  1'b0, 2'd0, 32'h0,         32'h0};
      tbl[1]  = '{1'b0, 3'b111, 5'd10, 5'd11, 5'd12, 1'b0, 3'b001, 5'd10, 1'b0, 2'd0, 32'h0,         32'h0};
      tbl[2]  = '{1'b0, 3'b111, 5'd10, 5'd11, 5'd12, 1'b0, 3'b010, 5'd11, 1'b1, 2'd0, 32'hDEAD000A,  32'hDEAD000A};
      tbl[3]  = '{1'b0, 3'b111, 5'd10, 5'd11, 5'd12, 1'b0, 3'b100, 5'd12, 1'b1, 2'd1, 32'hDEAD000B,  32'hDEAD000B};
      tbl[4]  = '{1'b0, 3'b111, 5'd10, 5'd11, 5'd12, 1'b0, 3'b001, 5'd10, 1'b1, 2'd2, 32'hDEAD000C,  32'hDEAD000C};
      tbl[5]  = '{1'b0, 3'b111, 5'd10, 5'd11, 5'd12, 1'b0, 3'b010, 5'd11, 1'b1, 2'd0, 32'hDEAD000A,  32'hDEAD000A};
      tbl[6]  = '{1'b0, 3'b111, 5'd10, 5'd11, 5'd12, 1'b0, 3'b100, 5'd12, 1'b1, 2'd1, 32'hDEAD000B,  32'hDEAD000B};
      tbl[7]  = '{1'b0, 3'b000, 5'd10, 5'd11, 5'd12, 1'b0, 3'b000, 5'd12, 1'b1, 2'd2, 32'hDEAD000C,  32'hDEAD000C};
      tbl[8]  = '{1'b0, 3'b000, 5'd10, 5'd11, 5'd12, 1'b0, 3'b000, 5'd12, 1'b0, 2'd0, 32'hDEAD000C,  32'hDEAD000C};
      tbl[9]  = '{1'b0, 3'b010, 5'd10, 5'd7,  5'd12, 1'b0, 3'b010, 5'd7,  1'b0, 2'd0, 32'hDEAD000C,  32'hDEAD000C};
      tbl[10] = '{1'b0, 3'b000, 5'd10, 5'd7,  5'd12, 1'b0, 3'b000, 5'd7,  1'b1, 2'd1, 32'hDEAD0007,  32'hDEAD0007};
      tbl[11] = '{1'b0, 3'b001, 5'd0,  5'd7,  5'd12, 1'b0, 3'b001, 5'd0,  1'b0, 2'd0, 32'hDEAD0007,  32'hDEAD0007};
      tbl[12] = '{1'b0, 3'b000, 5'd0,  5'd7,  5'd12, 1'b0, 3'b000, 5'd0,  1'b1, 2'd0, 32'h0,         32'hFFFFFFFF};
      tbl[13] = '{1'b0, 3'b000, 5'd0,  5'd7,  5'd12, 1'b0, 3'b000, 5'd0,  1'b0, 2'd0, 32'h0,         32'hFFFFFFFF};
      tbl[14] = '{1'b0, 3'b100, 5'd0,  5'd7,  5'd31, 1'b0, 3'b100, 5'd31, 1'b0, 2'd0, 32'h0,         32'hFFFFFFFF};
      tbl[15] = '{1'b0, 3'b011, 5'd0,  5'd7,  5'd31, 1'b1, 3'b000, 5'd31, 1'b0, 2'd0, 32'h0,         32'hFFFFFFFF};
      tbl[16] = '{1'b0, 3'b011, 5'd0,  5'd7,  5'd31, 1'b1, 3'b000, 5'd31, 1'b0, 2'd0, 32'h0,         32'hFFFFFFFF};
      tbl[17] = '{1'b0, 3'b011, 5'd0,  5'd7,  5'd31, 1'b1, 3'b000, 5'd31, 1'b0, 2'd0, 32'h0,         32'hFFFFFFFF};
      tbl[18] = '{1'b0, 3'b000, 5'd0,  5'd7,  5'd31, 1'b0, 3'b000, 5'd31, 1'b1, 2'd2, 32'hDEAD001F,  32'hDEAD001F};
      tbl[19] = '{1'b0, 3'b000, 5'd0,  5'd7,  5'd31, 1'b0, 3'b000, 5'd31, 1'b0, 2'd0, 32'hDEAD001F,  32'hDEAD001F};

      // ---- directed vector table ----
      for (int r = 0; r < 20; r++) begin
         Rst       = tbl[r].rst;
         if0.Req   = tbl[r].req;
         if0.Addr  = {tbl[r].a2, tbl[r].a1, tbl[r].a0};
         if0.Stall = tbl[r].stall;
         #1;
         chk($sformatf("row%0d gnt", r), 32'(if0.Gnt), 32'(tbl[r].gnt));
         @(posedge Clk); #1;
         chk($sformatf("row%0d sel", r), 32'(if0.Sel), 32'(tbl[r].sel));
         chk($sformatf("row%0d rdvalid", r), 32'(if0.RdValid), 32'(tbl[r].vld));
         chk($sformatf("row%0d rddata", r), if0.RdData, tbl[r].dat);
         chk($sformatf("row%0d rddata_nz", r), if1.RdData, tbl[r].dat_nz);
         if (tbl[r].vld) chk($sformatf("row%0d rdid", r), 32'(if0.RdId), 32'(tbl[r].id));
      end

      // ---- async reset while reads are in flight ----
      if0.Req = 3'b111; if0.Addr = {5'd12, 5'd11, 5'd10}; if0.Stall = 1'b0;
      #1 chk("ar gnt0", 32'(if0.Gnt), 32'b001);
      @(posedge Clk); #1;
      chk("ar gnt1", 32'(if0.Gnt), 32'b010);
      @(posedge Clk); #1;
      chk("ar valid before reset", 32'(if0.RdValid), 32'd1);
      if0.Req = 3'b110;
      #2 Rst = 1'b1;
      #1;
      chk("ar valid drops async", 32'(if0.RdValid), 32'd0);
      chk("ar sel cleared", 32'(if0.Sel), 32'd0);
      chk("ar data cleared", if0.RdData, 32'd0);
      chk("ar gnt in reset", 32'(if0.Gnt), 32'd0);
      @(posedge Clk); #1;
      chk("ar valid held in reset", 32'(if0.RdValid), 32'd0);
      #2 Rst = 1'b0;
      #1 chk("ar first gnt after reset", 32'(if0.Gnt), 32'b010);
      @(posedge Clk); #1;
      if0.Req = 3'b000;
      chk("ar no stale output", 32'(if0.RdValid), 32'd0);
      chk("ar sel", 32'(if0.Sel), 32'd11);
      @(posedge Clk); #1;
      chk("ar valid", 32'(if0.RdValid), 32'd1);
      chk("ar id", 32'(if0.RdId), 32'd1);
      chk("ar data", if0.RdData, 32'hDEAD000B);
      @(posedge Clk); #1;
      chk("ar single pulse", 32'(if0.RdValid), 32'd0);

      // ---- randomized traffic vs reference model ----
      Rst = 1'b1; #2; Rst = 1'b0;
      mptr = 0; m_sel = '0; m_vld = 1'b0; m_id = 0; m_dat = '0; m_dat_nz = '0;
      pend.delete();
      prev_g = -1;
      for (int i = 0; i < 3; i++) begin cur_req[i] = 1'b0; cur_addr[i] = '0; end
      for (int c = 0; c < 400; c++) begin
         // Requesters hold until granted, may occasionally withdraw.
         for (int i = 0; i < 3; i++) begin
            if (!cur_req[i] || prev_g == i) begin
               cur_req[i]  = ($urandom_range(0, 99) < 55);
               cur_addr[i] = ($urandom_range(0, 99) < 20) ? 5'd0 : 5'($urandom_range(0, 31));
            end else if ($urandom_range(0, 99) < 5) begin
               cur_req[i] = 1'b0;
            end
         end
         rq        = {cur_req[2], cur_req[1], cur_req[0]};
         if0.Req   = rq;
         if0.Addr  = {cur_addr[2], cur_addr[1], cur_addr[0]};
         if0.Stall = ($urandom_range(0, 99) < 20);
         #1;
         eg = -1;
         if (!if0.Stall) begin
            for (int off = 0; off < 3; off++) begin
               if (eg < 0 && cur_req[(mptr + off) % 3]) eg = (mptr + off) % 3;
            end
         end
         exp_g = (eg >= 0) ? 3'(1 << eg) : 3'b000;
         chk($sformatf("rnd%0d gnt", c), 32'(if0.Gnt), 32'(exp_g));
         @(posedge Clk); #1;
         if (!if0.Stall) begin
            m_vld = 1'b0;
            for (int q = 0; q < pend.size(); q++) pend[q].rem--;
            if (pend.size() > 0 && pend[0].rem == 0) begin
               it       = pend.pop_front();
               m_vld    = 1'b1;
               m_id     = it.id;
               m_dat    = (it.addr == 5'd0) ? 32'd0 : mux_f(it.addr);
               m_dat_nz = mux_f(it.addr);
            end
            if (eg >= 0) begin
               pend.push_back('{eg, cur_addr[eg], 1});
               m_sel = cur_addr[eg];
               mptr  = (eg + 1) % 3;
            end
         end
         prev_g = eg;
         chk($sformatf("rnd%0d sel", c), 32'(if0.Sel), 32'(m_sel));
         chk($sformatf("rnd%0d rdvalid", c), 32'(if0.RdValid), 32'(m_vld));
         chk($sformatf("rnd%0d rddata", c), if0.RdData, m_dat);
         chk($sformatf("rnd%0d rddata_nz", c), if1.RdData, m_dat_nz);
         if (m_vld) chk($sformatf("rnd%0d rdid", c), 32'(if0.RdId), 32'(m_id));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/regfile_rdport_arbiter.md
Name: regfile_rdport_arbiter

Overview:
- Shares one 32-way register-file read port (a 5-bit-select, 32-bit-wide 32:1 multiplexer) among NREQ requesters, e.g. ID operand A, ID operand B and the debug/trace port.
- Per cycle: picks at most one requester by round-robin and drives the registered mux select.
- Captures the mux output one cycle later and returns it tagged with the requester index.
- Sits between the decode/debug logic and the register-file mux, which stays purely combinational.

Parameters:
- NREQ, 3, number of requesters (2..4).
- DW, 32, data width of the mux output.
- AW, 5, register address width (mux select width).
- ZERO_R0, 1, when 1, reads of register 0 return 0 regardless of the mux output.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-high reset.
- Req  input  NREQ  per-requester read request, level; held until granted.
- Addr  input  NREQ*AW  packed register addresses; requester i uses bits [i*AW +: AW].
- Stall  input  1  freezes the whole pipeline when high.
- Gnt  output  NREQ  one-hot, combinational; request accepted this cycle.
- Sel  output  AW  registered select to the 32:1 mux.
- MuxDout  input  DW  combinational output of the 32:1 mux.
- RdData  output  DW  registered read data.
- RdValid  output  1  RdData/RdId valid this cycle.
- RdId  output  2  index of the requester that owns RdData.

Behaviour:
- Reset (async, Rst=1): Sel=0, RdData=0, RdValid=0, RdId=0, RR pointer Ptr=0, stage-1 valid V1=0, stage-1 id Id1=0. Gnt=0 while Rst is high.
- Pipeline: S0 grant, S1 mux lookup, S2 output register. Latency is 2 clocks from grant to RdValid. Throughput is 1 read per cycle.
- Arbitration (combinational, S0):
  - If Stall=0, search Req starting at index Ptr, wrapping modulo NREQ; the first set bit k gets Gnt[k]=1.
  - If Stall=1 or Req=0, then Gnt=0.
- On a clock edge with Gnt[k]=1: Sel<=Addr[k], Id1<=k, V1<=1, Ptr<=(k+1) mod NREQ.
- On a clock edge with Gnt=0 and Stall=0: V1<=0. Sel holds its last value (no spurious toggling). Ptr holds.
- S2 capture, on a clock edge with Stall=0:
  - RdValid<=V1 and RdId<=Id1.
  - If V1=1: RdData<=(ZERO_R0 && Sel==0) ? 0 : MuxDout.
  - If V1=0: RdData holds.
- Stall=1: all registers (Sel, V1, Id1, Ptr, RdData, RdValid, RdId) hold. An in-flight read is neither lost nor duplicated, and RdValid stays asserted if it was asserted. Requesters keep Req high.
- Requester contract: Req[i] and Addr[i] are held stable until Gnt[i] is seen. Deasserting Req before grant is allowed and simply withdraws the request.
- Fairness: with all NREQ requests continuously asserted, grants rotate 0,1,..,NREQ-1,0,… Any asserted requester is served within NREQ cycles of non-stalled operation.
- Requester indices >= NREQ never appear. The wrap is mod NREQ, not mod 4.
- Reset mid-operation: in-flight reads are discarded (V1=0, RdValid=0) and the pointer returns to 0. No partial output is produced after Rst releases.
- A single request over many cycles is granted every cycle, so the same requester may issue back-to-back reads.

Test Plan:
- Reset: Rst=1 with Req=3'b111 -> Gnt=0, Sel=0, RdValid=0, RdData=0. Release Rst -> first grant is Gnt=3'b001.
- Single read: Req=3'b010, Addr1=5'd7, mux model returns 32'hDEAD0007 for Sel=7 -> Gnt=3'b010 in cycle t, Sel=7 at t+1, RdValid=1, RdId=1, RdData=32'hDEAD0007 at t+2.
- Round-robin: Req=3'b111 held for 6 cycles, requester i asking for register 10+i -> grant order 0,1,2,0,1,2; RdId sequence 0,1,2,0,1,2; RdData follows the mux value for each register; no gaps.
- Zero register: Addr0=0, mux model returns 32'hFFFFFFFF for Sel=0, ZERO_R0=1 -> RdData=0, RdValid=1. With ZERO_R0=0 -> RdData=32'hFFFFFFFF.
- Stall mid-flight: grant requester 2 (Addr=5'd31), then Stall=1 for 3 cycles -> Gnt=0 and Sel=31 held, no RdValid pulse during Stall; after release, exactly one RdValid with RdId=2 and RdData=mux(31).
- Async reset mid-flight: assert Rst between grant and output -> RdValid stays 0 immediately (no clock needed) and Ptr=0; after release, Req=3'b110 grants requester 1 first.
